// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM states,
// default timeout and the alignment legality rule.
package mem_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int TIMEOUT_DEF = 255;

  // True when the access can never reach memory: size 3, or a natural-alignment violation.
  function automatic logic is_bad(input logic [1:0] size, input logic [1:0] off);
    case (size_e'(size))
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return (off != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: store byte-lane replication with write mask, and
// load lane extraction with sign/zero extension.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_wdata,
  output logic [31:0] o_st_wdata,
  output logic [7:0]  o_st_wmask,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_off,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [31:0]        w_lane;
  logic signed [7:0]  w_lane_b;
  logic signed [15:0] w_lane_h;

  assign w_lane   = i_ld_rdata >> {i_ld_off, 3'b000};
  assign w_lane_b = w_lane[7:0];
  assign w_lane_h = w_lane[15:0];

  always_comb begin
    o_st_wdata = 32'h0;
    o_st_wmask = 8'h00;
    case (size_e'(i_st_size))
      SZ_B: begin
        o_st_wdata = {4{i_st_wdata[7:0]}};
        o_st_wmask = 8'h01 << i_st_off;
      end
      SZ_H: begin
        o_st_wdata = {2{i_st_wdata[15:0]}};
        o_st_wmask = 8'h03 << i_st_off;
      end
      SZ_W: begin
        o_st_wdata = i_st_wdata;
        o_st_wmask = 8'h0F;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_ld_data = 32'h0;
    case (size_e'(i_ld_size))
      SZ_B:    o_ld_data = i_ld_unsigned ? {24'h0, w_lane_b} : {{24{w_lane_b[7]}}, w_lane_b};
      SZ_H:    o_ld_data = i_ld_unsigned ? {16'h0, w_lane_h} : {{16{w_lane_h[15]}}, w_lane_h};
      SZ_W:    o_ld_data = w_lane;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator: one request per handshake, word-aligned memory access,
// bounded wait with timeout, registered extended response.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_wen,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e      r_state;
  state_e      w_state_nxt;
  size_e       r_size;
  logic        r_wen;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_mem_wdata;
  logic [7:0]  r_mem_wmask;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic [15:0] r_cnt;

  logic        w_bad;
  logic        w_accept;
  logic        w_done;
  logic        w_tmo;
  logic        w_cnt_hit;
  logic [31:0] w_st_wdata;
  logic [7:0]  w_st_wmask;
  logic [31:0] w_ld_data;

  assign w_bad     = is_bad(req_size, req_addr[1:0]);
  assign w_cnt_hit = (r_cnt >= CNT_LAST);

  mem_lsu_align u_align (
    .i_st_size     (req_size),
    .i_st_off      (req_addr[1:0]),
    .i_st_wdata    (req_wdata),
    .o_st_wdata    (w_st_wdata),
    .o_st_wmask    (w_st_wmask),
    .i_ld_size     (r_size),
    .i_ld_off      (r_addr[1:0]),
    .i_ld_unsigned (r_uns),
    .i_ld_rdata    (mem_rdata),
    .o_ld_data     (w_ld_data)
  );

  // Completion wins over timeout when both land in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_bad ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ready && mem_rvalid) begin
          w_done      = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (w_cnt_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (mem_ready) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          w_done      = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (w_cnt_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_wen        <= 1'b0;
      r_uns        <= 1'b0;
      r_size       <= SZ_B;
      r_addr       <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_mem_wmask  <= 8'h00;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
      r_cnt        <= 16'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_wen        <= req_wen;
        r_uns        <= req_unsigned;
        r_size       <= size_e'(req_size);
        r_addr       <= req_addr;
        r_mem_wdata  <= w_st_wdata;
        r_mem_wmask  <= req_wen ? w_st_wmask : 8'h00;
        r_resp_rdata <= 32'h0;
        r_resp_err   <= w_bad;
        r_cnt        <= 16'h0;
      end else if ((r_state == ST_REQ || r_state == ST_WAIT) && r_cnt != 16'hFFFF) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_done) r_resp_rdata <= r_wen ? 32'h0 : w_ld_data;
      if (w_tmo) begin
        r_resp_err   <= 1'b1;
        r_resp_rdata <= 32'h0;
      end
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_valid  = (r_state == ST_REQ);
  assign mem_wen    = r_wen;
  assign mem_raddr  = {r_addr[31:2], 2'b00};
  assign mem_waddr  = {r_addr[31:2], 2'b00};
  assign mem_wdata  = r_mem_wdata;
  assign mem_wmask  = r_mem_wmask;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed vector table, multi-cycle corner sequences, and
// randomized traffic against a byte-addressed reference memory.
`timescale 1ns/1ps
module tb_mem_lsu;

  localparam int          TMO      = 8;
  localparam logic [31:0] BASE     = 32'h8000_0000;
  localparam int          M_ZERO   = 0;
  localparam int          M_RAND   = 1;
  localparam int          M_STALL  = 2;
  localparam int          M_NOISE  = 3;
  localparam int          M_ACCEPT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  mem_lsu #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          mode     = M_ZERO;
  logic        ovr_en   = 1'b1;
  logic [31:0] ovr_data = 32'h0;
  logic        load_arr = 1'b0;
  logic        commit_en = 1'b0;
  logic [31:0] init_arr [0:15];
  logic [31:0] mem_arr  [0:15];
  logic [7:0]  ref_bytes [0:63];
  logic        pend;
  int          wcnt;
  int          mv_cnt;

  logic        cap_mv, cap_wen;
  logic [31:0] cap_wdata, cap_raddr, cap_waddr;
  logic [7:0]  cap_wmask;

  initial mv_cnt = 0;
  always @(posedge clk) if (mem_valid) mv_cnt <= mv_cnt + 1;

  always_comb mem_rdata = ovr_en ? ovr_data : mem_arr[mem_raddr[5:2]];

  // Memory array with byte-masked write commit on the request handshake.
  always @(posedge clk) begin
    if (load_arr) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= init_arr[i];
    end else if (commit_en && mem_valid && mem_ready && mem_wen) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem_arr[mem_waddr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Memory responder; in random mode latency is capped so the timeout is never reached.
  always @(negedge clk) begin
    case (mode)
      M_ZERO:   begin mem_ready = 1'b1; mem_rvalid = 1'b1; pend = 1'b0; wcnt = 0; end
      M_STALL:  begin mem_ready = 1'b0; mem_rvalid = 1'b0; pend = 1'b0; wcnt = 0; end
      M_NOISE:  begin mem_ready = 1'b0; mem_rvalid = 1'b1; pend = 1'b0; wcnt = 0; end
      M_ACCEPT: begin mem_ready = 1'b1; mem_rvalid = 1'b0; pend = 1'b0; wcnt = 0; end
      default: begin
        if (pend) begin
          mem_ready  = 1'b0;
          mem_rvalid = (wcnt >= 2) || (1'($urandom_range(1)) == 1'b1);
          if (mem_rvalid) begin pend = 1'b0; wcnt = 0; end
          else wcnt++;
        end else if (mem_valid) begin
          mem_ready = (wcnt >= 2) || (1'($urandom_range(1)) == 1'b1);
          if (mem_ready) begin
            mem_rvalid = 1'($urandom_range(1));
            pend = !mem_rvalid;
            wcnt = 0;
          end else begin
            mem_rvalid = 1'b0;
            wcnt++;
          end
        end else begin
          mem_ready  = 1'($urandom_range(1));
          mem_rvalid = 1'($urandom_range(1));
        end
      end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic wen, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
    int n;
    req_wen = wen; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    chk("req_ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0; cap_mv = 1'b0; cap_wen = 1'b0;
    cap_wdata = 32'h0; cap_wmask = 8'h0; cap_raddr = 32'h0; cap_waddr = 32'h0;
    while (!resp_valid && n < 40) begin
      if (mem_valid) begin
        cap_mv = 1'b1; cap_wen = mem_wen; cap_wdata = mem_wdata;
        cap_wmask = mem_wmask; cap_raddr = mem_raddr; cap_waddr = mem_waddr;
      end
      @(posedge clk); #1;
      n++;
    end
    chk("resp_within_bound", 32'(resp_valid), 32'd1);
    lat = n + 1;
    rdata = resp_rdata;
    err = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  // Byte-level reference: legality, little-endian gather and two's-complement extension.
  task automatic ref_op(input logic wen, input logic [1:0] size, input logic uns, input int a,
                        input logic [31:0] wdata, output logic [31:0] er, output logic ee);
    int nb;
    longint v;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    ee = (size == 2'd3) || (a % nb != 0);
    er = 32'h0;
    if (ee) return;
    if (wen) begin
      for (int i = 0; i < nb; i++) ref_bytes[a + i] = wdata[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < nb; i++) v += longint'(ref_bytes[a + i]) << (8 * i);
      if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
      er = 32'(v);
    end
  endtask

  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [31:0] e_rdata;
    logic        e_err;
    logic [31:0] e_wdata;
    logic [7:0]  e_wmask;
    int          e_lat;
  } vec_t;

  vec_t vt [12];

  initial begin
    #200000;
    $display("FAIL watchdog: actual=no finish required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdata, er, exp_w;
    logic        err, ee, wen, uns;
    logic [1:0]  size;
    logic [31:0] wdata;
    int          lat, mv0, a, nb, nresp, last;

    vt[0]  = '{1'b1, 2'd0, 1'b0, 32'h8000_0003, 32'h1234_56AB, 32'h0,          32'h0,          1'b0, 32'hABAB_ABAB, 8'h08, 2};
    vt[1]  = '{1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0,         32'h8001_7FFF, 32'hFFFF_8001, 1'b0, 32'h0,         8'h00, 2};
    vt[2]  = '{1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'h0,         32'h8001_7FFF, 32'h0000_8001, 1'b0, 32'h0,         8'h00, 2};
    vt[3]  = '{1'b0, 2'd2, 1'b0, 32'h8000_0006, 32'h0,         32'h1111_1111, 32'h0,          1'b1, 32'h0,         8'h00, 1};
    vt[4]  = '{1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'hDEAD_BEEF, 32'h0,          32'h0,          1'b0, 32'hBEEF_BEEF, 8'h0C, 2};
    vt[5]  = '{1'b1, 2'd2, 1'b0, 32'h8000_0004, 32'hCAFE_F00D, 32'h0,          32'h0,          1'b0, 32'hCAFE_F00D, 8'h0F, 2};
    vt[6]  = '{1'b0, 2'd0, 1'b0, 32'h8000_0001, 32'h0,         32'h1122_83FF, 32'hFFFF_FF83, 1'b0, 32'h0,         8'h00, 2};
    vt[7]  = '{1'b0, 2'd0, 1'b1, 32'h8000_0001, 32'h0,         32'h1122_83FF, 32'h0000_0083, 1'b0, 32'h0,         8'h00, 2};
    vt[8]  = '{1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0,         32'h5555_5555, 32'h0,          1'b1, 32'h0,         8'h00, 1};
    vt[9]  = '{1'b1, 2'd1, 1'b0, 32'h8000_0001, 32'h0000_1234, 32'h0,          32'h0,          1'b1, 32'h0,         8'h00, 1};
    vt[10] = '{1'b0, 2'd2, 1'b0, 32'h8000_0008, 32'h0,         32'h89AB_CDEF, 32'h89AB_CDEF, 1'b0, 32'h0,         8'h00, 2};
    vt[11] = '{1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0,         32'h7F00_0000, 32'h0000_007F, 1'b0, 32'h0,         8'h00, 2};

    rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready",  32'(req_ready),  32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err",   32'(resp_err),   32'd0);
    chk("rst_mem_valid",  32'(mem_valid),  32'd0);
    chk("rst_mem_wen",    32'(mem_wen),    32'd0);
    chk("rst_mem_wmask",  32'(mem_wmask),  32'd0);
    chk("rst_mem_wdata",  mem_wdata,       32'd0);
    chk("rst_mem_raddr",  mem_raddr,       32'd0);
    chk("rst_resp_rdata", resp_rdata,      32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      ovr_data = vt[i].rd;
      do_op(vt[i].wen, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, rdata, err, lat);
      chk($sformatf("v%0d_rdata", i), rdata, vt[i].e_rdata);
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].e_err));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].e_lat));
      chk($sformatf("v%0d_mem_access", i), 32'(cap_mv), 32'(!vt[i].e_err));
      if (!vt[i].e_err) begin
        chk($sformatf("v%0d_mem_wen", i), 32'(cap_wen), 32'(vt[i].wen));
        if (vt[i].wen) begin
          chk($sformatf("v%0d_waddr", i), cap_waddr, {vt[i].addr[31:2], 2'b00});
          chk($sformatf("v%0d_wdata", i), cap_wdata, vt[i].e_wdata);
          chk($sformatf("v%0d_wmask", i), 32'(cap_wmask), 32'(vt[i].e_wmask));
        end else begin
          chk($sformatf("v%0d_raddr", i), cap_raddr, {vt[i].addr[31:2], 2'b00});
        end
      end
    end

    mode = M_STALL;
    mv0 = mv_cnt;
    do_op(1'b0, 2'd2, 1'b0, BASE + 32'h20, 32'h0, rdata, err, lat);
    chk("tmo_err",        32'(err),          32'd1);
    chk("tmo_rdata",      rdata,             32'd0);
    chk("tmo_latency",    32'(lat),          32'(TMO + 1));
    chk("tmo_req_cycles", 32'(mv_cnt - mv0), 32'(TMO));
    mode = M_NOISE;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("late_rvalid_no_resp", 32'(resp_valid), 32'd0);
      chk("late_rvalid_idle",    32'(req_ready),  32'd1);
    end

    mode = M_ACCEPT;
    req_wen = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = BASE; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wait_seq_req_mem_valid", 32'(mem_valid), 32'd1);
    @(posedge clk); #1;
    chk("wait_seq_in_wait_ready", 32'(req_ready), 32'd0);
    chk("wait_seq_in_wait_mv",    32'(mem_valid), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_wait_req_ready",  32'(req_ready),  32'd1);
    chk("rst_wait_mem_valid",  32'(mem_valid),  32'd0);
    chk("rst_wait_resp_valid", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    req_wen = 1'b0; req_size = 2'd2; req_addr = BASE + 32'h2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_resp_pending_valid", 32'(resp_valid), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_resp_discard_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_discard_err",   32'(resp_err),   32'd0);
    chk("rst_resp_discard_ready", 32'(req_ready),  32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 64; i++) ref_bytes[i] = 8'($urandom);
    for (int w = 0; w < 16; w++)
      init_arr[w] = {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
    load_arr = 1'b1;
    @(posedge clk); #1;
    load_arr = 1'b0; commit_en = 1'b1; ovr_en = 1'b0; mode = M_RAND;
    for (int k = 0; k < 80; k++) begin
      wen   = 1'($urandom_range(1));
      size  = ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(2));
      uns   = 1'($urandom_range(1));
      wdata = $urandom;
      a     = $urandom_range(63);
      nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      if ($urandom_range(3) != 0) a = a - (a % nb);
      do_op(wen, size, uns, BASE + 32'(a), wdata, rdata, err, lat);
      ref_op(wen, size, uns, a, wdata, er, ee);
      chk($sformatf("rnd%0d_rdata", k), rdata, er);
      chk($sformatf("rnd%0d_err", k), 32'(err), 32'(ee));
    end

    mode = M_ZERO;
    ref_op(1'b0, 2'd2, 1'b0, 16, 32'h0, exp_w, ee);
    req_wen = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = BASE + 32'h10;
    req_valid = 1'b1; resp_ready = 1'b1;
    nresp = 0; last = -1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        chk($sformatf("b2b_rdata_c%0d", c), resp_rdata, exp_w);
        if (last >= 0) chk("b2b_gap", 32'(c - last), 32'd3);
        else chk("b2b_first_cycle", 32'(c), 32'd2);
        last = c;
        nresp++;
      end
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    chk("b2b_resp_count", 32'(nresp), 32'd4);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
